exe_unit_issuer: RTL and testbench

- Command initiator for the execution unit: accepts operation commands (a, b, op) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the execution unit, waits its fixed pipeline latency, then captures o_out/o_status.
- Presents each captured result with its op on a valid/ready result port.
- Sits between the control/sequencer logic and exe_unit_w6. It replaces the bench-style direct driving of i_a/i_b/i_op.

---
 rtl/exe_unit_issuer_if.sv | 49 ++++
 rtl/exe_unit_issuer.sv | 148 ++++++++++++++
 tb/tb_exe_unit_issuer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_unit_issuer_if.sv
// Command, execution-unit and result signals of the exe_unit_issuer.
// The master modport is the issuer; the slave modport is its environment.
interface exe_unit_issuer_if #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic [BITS-1:0] i_cmd_a;
  logic [BITS-1:0] i_cmd_b;
  logic [1:0]      i_cmd_op;

  logic [BITS-1:0] o_exe_a;
  logic [BITS-1:0] o_exe_b;
  logic [1:0]      o_exe_op;
  logic [BITS-1:0] i_exe_out;
  logic [3:0]      i_exe_status;

  logic            o_res_valid;
  logic            i_res_ready;
  logic [BITS-1:0] o_res_out;
  logic [3:0]      o_res_status;
  logic [1:0]      o_res_op;

  logic            o_busy;
  logic [CW-1:0]   o_count;

  modport master (
    input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
    output o_cmd_ready,
    output o_exe_a, o_exe_b, o_exe_op,
    input  i_exe_out, i_exe_status,
    output o_res_valid, o_res_out, o_res_status, o_res_op,
    input  i_res_ready,
    output o_busy, o_count
  );

  modport slave (
    output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
    input  o_cmd_ready,
    input  o_exe_a, o_exe_b, o_exe_op,
    output i_exe_out, i_exe_status,
    input  o_res_valid, o_res_out, o_res_status, o_res_op,
    output i_res_ready,
    input  o_busy, o_count
  );
endinterface

// File: rtl/exe_unit_issuer.sv
// Buffers commands in a small FIFO, issues them one at a time to the execution
// unit, waits its fixed latency and returns each result over a valid/ready port.
module exe_unit_issuer #(
  parameter int BITS    = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  exe_unit_issuer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Command storage; pointers carry the reset, the array itself does not.
  logic [BITS-1:0] mem_a  [DEPTH];
  logic [BITS-1:0] mem_b  [DEPTH];
  logic [1:0]      mem_op [DEPTH];

  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            full;
  logic            push;
  logic            pop;

  state_t          state_reg;
  logic [WW-1:0]   wait_reg;
  logic [BITS-1:0] exe_a_reg;
  logic [BITS-1:0] exe_b_reg;
  logic [1:0]      exe_op_reg;
  logic            res_valid_reg;
  logic [BITS-1:0] res_out_reg;
  logic [3:0]      res_status_reg;
  logic [1:0]      res_op_reg;
  logic            busy_reg;

  // Ready depends only on stored occupancy, so a pop never frees a full slot
  // in the same cycle.
  assign full = (count_reg == CW'(DEPTH));
  assign push = bus.i_cmd_valid && !full;
  assign pop  = (state_reg == IDLE) && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem_a[wr_ptr_reg]  <= bus.i_cmd_a;
      mem_b[wr_ptr_reg]  <= bus.i_cmd_b;
      mem_op[wr_ptr_reg] <= bus.i_cmd_op;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // Issue FSM; the FIFO head read is registered straight into o_exe_*.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      wait_reg       <= '0;
      exe_a_reg      <= '0;
      exe_b_reg      <= '0;
      exe_op_reg     <= '0;
      res_valid_reg  <= 1'b0;
      res_out_reg    <= '0;
      res_status_reg <= '0;
      res_op_reg     <= '0;
      busy_reg       <= 1'b0;
    end else begin
      busy_reg <= (count_next != '0);
      case (state_reg)
        IDLE: begin
          if (pop) begin
            exe_a_reg  <= mem_a[rd_ptr_reg];
            exe_b_reg  <= mem_b[rd_ptr_reg];
            exe_op_reg <= mem_op[rd_ptr_reg];
            wait_reg   <= WW'(LATENCY - 1);
            state_reg  <= WAIT;
            busy_reg   <= 1'b1;
          end
        end
        WAIT: begin
          busy_reg <= 1'b1;
          if (wait_reg == '0) begin
            res_out_reg    <= bus.i_exe_out;
            res_status_reg <= bus.i_exe_status;
            res_op_reg     <= exe_op_reg;
            res_valid_reg  <= 1'b1;
            state_reg      <= RESP;
          end else begin
            wait_reg <= wait_reg - 1'b1;
          end
        end
        RESP: begin
          if (bus.i_res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            busy_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready  = !full;
  assign bus.o_exe_a      = exe_a_reg;
  assign bus.o_exe_b      = exe_b_reg;
  assign bus.o_exe_op     = exe_op_reg;
  assign bus.o_res_valid  = res_valid_reg;
  assign bus.o_res_out    = res_out_reg;
  assign bus.o_res_status = res_status_reg;
  assign bus.o_res_op     = res_op_reg;
  assign bus.o_busy       = busy_reg;
  assign bus.o_count      = count_reg;
endmodule

// File: tb/tb_exe_unit_issuer.sv
// Scoreboard bench for exe_unit_issuer with a behavioural stand-in for the
// execution unit; expected results are queued at command acceptance.
module tb_exe_unit_issuer;
  localparam int BITS  = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] out;
    logic [3:0] status;
    logic [1:0] op;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   last_push_cyc = 0;
  int   ready_mode = 0;   // 0 low, 1 high, 2 random
  exp_t exp_q[$];
  int   issue_q[$];

  exe_unit_issuer_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  exe_unit_issuer #(.BITS(BITS), .DEPTH(DEPTH), .LATENCY(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stand-in execution unit: combinational, so its output is valid one edge
  // after the operands are registered.
  function automatic logic [11:0] ref_exe(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    logic [7:0] r;
    logic [3:0] s;
    case (op)
      2'b00:   r = a - b;
      2'b01:   r = {5'b0, a > b, a == b, a < b};
      2'b10:   r = a << b[2:0];
      default: r = a ^ (8'd1 << b[2:0]);
    endcase
    s = {a < b, a == b, r == 8'd0, r[7]};
    return {s, r};
  endfunction

  always_comb {bus.i_exe_status, bus.i_exe_out} = ref_exe(bus.o_exe_a, bus.o_exe_b, bus.o_exe_op);

  always @(posedge clk) begin
    #2;
    bus.i_res_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (!rst && bus.o_res_valid && bus.i_res_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL res_unexpected: got out=%0h op=%0d required no result",
                 bus.o_res_out, bus.o_res_op);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] result out=%02h status=%h op=%0d (exp %02h %h %0d)",
                 bus.o_res_out, bus.o_res_status, bus.o_res_op, e.out, e.status, e.op);
        check("res_out", bus.o_res_out, e.out);
        check("res_status", bus.o_res_status, e.status);
        check("res_op", bus.o_res_op, e.op);
      end
    end
  end

  // Records the cycle of every change of the issued operands.
  logic [17:0] prev_exe = '0;
  always @(negedge clk) begin
    if ({bus.o_exe_a, bus.o_exe_b, bus.o_exe_op} != prev_exe) begin
      issue_q.push_back(cyc);
    end
    prev_exe = {bus.o_exe_a, bus.o_exe_b, bus.o_exe_op};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [11:0] r;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_a     = a;
    bus.i_cmd_b     = b;
    bus.i_cmd_op    = op;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.o_cmd_ready && !rst) begin
        r = ref_exe(a, b, op);
        exp_q.push_back('{out: r[7:0], status: r[11:8], op: op});
        $display("[TB] cmd a=%02h b=%02h op=%0d", a, b, op);
        tick();
        last_push_cyc = cyc;
        bus.i_cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    n_tests++;
    n_fail++;
    $display("[TB] FAIL cmd_timeout: got ready=0 required ready=1 within 200 cycles");
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.o_busy && !bus.o_res_valid) done = 1;
    end
    check("drain_done", done, 1);
    tick();
  endtask

  logic [7:0] h_out;
  logic [3:0] h_status;
  logic [1:0] h_op;
  bit         seen;

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_a     = '0;
    bus.i_cmd_b     = '0;
    bus.i_cmd_op    = '0;
    bus.i_res_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_res_valid", bus.o_res_valid, 0);
    check("rst_exe", {bus.o_exe_a, bus.o_exe_b, bus.o_exe_op}, 0);
    check("rst_res", {bus.o_res_out, bus.o_res_status, bus.o_res_op}, 0);
    check("rst_count", bus.o_count, 0);
    check("rst_busy", bus.o_busy, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    tick();

    // Basic subtract with exact timing.
    ready_mode = 1;
    drive_cmd(8'd91, 8'd41, 2'b00);
    @(negedge clk);
    check("basic_count", bus.o_count, 1);
    check("basic_busy", bus.o_busy, 1);
    tick();
    @(negedge clk);
    check("basic_exe_a", bus.o_exe_a, 91);
    check("basic_exe_op", bus.o_exe_op, 0);
    check("basic_valid_early", bus.o_res_valid, 0);
    tick();
    @(negedge clk);
    check("basic_valid", bus.o_res_valid, 1);
    check("basic_out", bus.o_res_out, 8'h32);
    tick();
    wait_drain();

    // Back-to-back issue spacing.
    issue_q.delete();
    drive_cmd(8'd127, 8'd1, 2'b00);
    drive_cmd(8'd91, 8'd41, 2'b00);
    wait_drain();
    check("b2b_issues", (issue_q.size() >= 2), 1);
    if (issue_q.size() >= 2) begin
      check("b2b_first_issue", issue_q[0] - (last_push_cyc - 1), 1);
      check("b2b_interval", issue_q[1] - issue_q[0], 3);
    end

    // FIFO full with the result port stalled.
    ready_mode = 0;
    for (int i = 0; i < 5; i++) drive_cmd(8'(10 * i + 20), 8'(i + 3), 2'(i));
    @(negedge clk);
    check("full_count", bus.o_count, 4);
    check("full_ready", bus.o_cmd_ready, 0);
    tick();
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_a = 8'hAA;
    bus.i_cmd_b = 8'h05;
    bus.i_cmd_op = 2'b10;
    tick();
    @(negedge clk);
    check("full_stall_ready", bus.o_cmd_ready, 0);
    check("full_stall_count", bus.o_count, 4);
    tick();
    bus.i_cmd_valid = 1'b0;
    ready_mode = 1;
    drive_cmd(8'hAA, 8'h05, 2'b10);
    wait_drain();

    // Backpressure: result held, no second issue.
    ready_mode = 0;
    drive_cmd(8'h3C, 8'h4D, 2'b01);
    drive_cmd(8'h11, 8'h22, 2'b00);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus.o_res_valid) seen = 1;
      tick();
    end
    check("bp_valid_seen", seen, 1);
    h_out = bus.o_res_out;
    h_status = bus.o_res_status;
    h_op = bus.o_res_op;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_hold_res", {bus.o_res_valid, bus.o_res_out, bus.o_res_status, bus.o_res_op},
            {1'b1, h_out, h_status, h_op});
      check("bp_hold_exe", {bus.o_exe_a, bus.o_exe_b}, 16'h3C4D);
      check("bp_count", bus.o_count, 1);
      tick();
    end
    ready_mode = 1;
    wait_drain();

    // Reset while a command is in WAIT with two more queued.
    ready_mode = 0;
    drive_cmd(8'h50, 8'h10, 2'b00);
    drive_cmd(8'h61, 8'h02, 2'b10);
    drive_cmd(8'h72, 8'h03, 2'b11);
    drive_cmd(8'h83, 8'h04, 2'b01);
    ready_mode = 1;
    tick();
    ready_mode = 0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_wait_count", bus.o_count, 2);
    check("mid_wait_exe_a", bus.o_exe_a, 8'h61);
    check("mid_wait_valid", bus.o_res_valid, 0);
    tick();
    @(negedge clk);
    check("rst2_exe", {bus.o_exe_a, bus.o_exe_b, bus.o_exe_op}, 0);
    check("rst2_res", {bus.o_res_valid, bus.o_res_out, bus.o_res_status, bus.o_res_op}, 0);
    check("rst2_count", bus.o_count, 0);
    check("rst2_busy", bus.o_busy, 0);
    tick();
    rst = 1'b0;
    ready_mode = 1;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus.o_res_valid) seen = 1;
      tick();
    end
    check("rst2_no_result", seen, 0);
    check("rst2_cmd_ready", bus.o_cmd_ready, 1);

    // Op passthrough.
    drive_cmd(8'hC1, 8'h81, 2'b11);
    tick();
    @(negedge clk);
    check("pass_op3", {bus.o_exe_a, bus.o_exe_op}, {8'hC1, 2'b11});
    tick();
    wait_drain();
    drive_cmd(8'hC1, 8'h81, 2'b10);
    tick();
    @(negedge clk);
    check("pass_op2", {bus.o_exe_a, bus.o_exe_op}, {8'hC1, 2'b10});
    tick();
    wait_drain();

    // Randomised traffic with random result backpressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      drive_cmd(8'($urandom), 8'($urandom), 2'($urandom));
    end
    ready_mode = 1;
    wait_drain();
    check("final_count", bus.o_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got no finish required finish before 300000");
    $fatal(1, "timeout");
  end
endmodule
